// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: forward-port bundle,
// sequencer state encoding and default mult/div latency.
package hazard_sequencer_pkg;

  localparam int MD_LATENCY_DEFAULT = 4;
  localparam int CNT_W_DEFAULT      = 4;

  typedef struct packed {
    logic        write;
    logic [4:0]  addr;
    logic [31:0] value;
    logic        eval;
  } ForwardPort;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALTED  = 2'd2
  } HazState;

endpackage

// File: rtl/hazard_sequencer_match.sv
// Load-use match for one forward port: the producer writes a register the ID
// instruction reads, and its value is not yet evaluated.
module hazard_match
  import hazard_sequencer_pkg::*;
(
  input  ForwardPort  port_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic        uses_rs_i,
  input  logic        uses_rt_i,
  output logic        match_o
);

  logic rs_hit;
  logic rt_hit;
  logic unused_value;

  assign rs_hit  = uses_rs_i & (port_i.addr == rs_addr_i);
  assign rt_hit  = uses_rt_i & (port_i.addr == rt_addr_i);
  // $0 is hardwired, so writes to it never create a dependency
  assign match_o = port_i.write & ~port_i.eval & (port_i.addr != 5'd0) & (rs_hit | rt_hit);

  assign unused_value = ^port_i.value;

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller: merges memory wait, mult/div occupancy,
// load-use interlocks, branch redirects and halt into per-stage hold/clear.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] idRsAddr,
  input  logic [4:0] idRtAddr,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  ForwardPort exPort,
  input  ForwardPort memPort,
  input  logic       mdStart,
  input  logic       redirect,
  input  logic       haltId,
  input  logic       memReq,
  input  logic       memAck,
  output logic       pcHold,
  output logic       ifIdHold,
  output logic       ifIdClear,
  output logic       idExHold,
  output logic       idExClear,
  output logic       exMemHold,
  output logic       exMemClear,
  output logic       memWbHold,
  output logic       memWbClear,
  output logic       mdBusy,
  output logic [1:0] state
);

  localparam bit             MD_STALLS = (MD_LATENCY > 1);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

  HazState          state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic ex_match;
  logic mem_match;
  logic lu_stall;
  logic mem_stall;
  logic md_stall;

  hazard_match u_match_ex (
    .port_i    (exPort),
    .rs_addr_i (idRsAddr),
    .rt_addr_i (idRtAddr),
    .uses_rs_i (idUsesRs),
    .uses_rt_i (idUsesRt),
    .match_o   (ex_match)
  );

  hazard_match u_match_mem (
    .port_i    (memPort),
    .rs_addr_i (idRsAddr),
    .rt_addr_i (idRtAddr),
    .uses_rs_i (idUsesRs),
    .uses_rt_i (idUsesRt),
    .match_o   (mem_match)
  );

  assign lu_stall  = ex_match | mem_match;
  assign mem_stall = memReq & ~memAck;
  assign md_stall  = (state_q == MD_WAIT);

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        // mdStart under a memory wait is retried: ID/EX stays held with it
        if (mdStart && !mem_stall && MD_STALLS) begin
          state_d  = MD_WAIT;
          md_cnt_d = MD_LOAD;
        end else if (haltId && !mem_stall && !lu_stall) begin
          state_d = HALTED;
        end
      end
      MD_WAIT: begin
        md_cnt_d = md_cnt_q - CNT_W'(1);
        if (md_cnt_q == CNT_W'(1)) state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    pcHold     = 1'b0;
    ifIdHold   = 1'b0;
    ifIdClear  = 1'b0;
    idExHold   = 1'b0;
    idExClear  = 1'b0;
    exMemHold  = 1'b0;
    exMemClear = 1'b0;
    memWbHold  = 1'b0;
    memWbClear = 1'b0;
    if (!reset) begin
      pcHold     = 1'b1;
      ifIdClear  = 1'b1;
      idExClear  = 1'b1;
      exMemClear = 1'b1;
      memWbClear = 1'b1;
    end else if (mem_stall) begin
      pcHold     = 1'b1;
      ifIdHold   = 1'b1;
      idExHold   = 1'b1;
      exMemHold  = 1'b1;
      memWbClear = 1'b1;
    end else if (md_stall) begin
      pcHold     = 1'b1;
      ifIdHold   = 1'b1;
      idExHold   = 1'b1;
      exMemClear = 1'b1;
    end else if (state_q == HALTED) begin
      // ID only ever sees bubbles once halted, so interlocks are moot here
      pcHold    = 1'b1;
      ifIdClear = 1'b1;
    end else if (lu_stall) begin
      pcHold    = 1'b1;
      ifIdHold  = 1'b1;
      idExClear = 1'b1;
    end else if (redirect) begin
      ifIdClear = 1'b1;
    end
  end

  assign mdBusy = (md_cnt_q != '0);
  assign state  = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios against fixed
// command patterns, then randomized traffic against a behavioural model.
module tb_hazard_sequencer;
  import hazard_sequencer_pkg::*;

  localparam int LAT = 4;

  // {pcHold, ifIdHold, ifIdClear, idExHold, idExClear, exMemHold, exMemClear,
  //  memWbHold, memWbClear, mdBusy, state[1:0]}
  localparam logic [11:0] O_IDLE     = 12'b0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [11:0] O_LU       = 12'b1_1_0_0_1_0_0_0_0_0_00;
  localparam logic [11:0] O_MEM      = 12'b1_1_0_1_0_1_0_0_1_0_00;
  localparam logic [11:0] O_MD       = 12'b1_1_0_1_0_0_1_0_0_1_01;
  localparam logic [11:0] O_RED      = 12'b0_0_1_0_0_0_0_0_0_0_00;
  localparam logic [11:0] O_HALT     = 12'b1_0_1_0_0_0_0_0_0_0_10;
  localparam logic [11:0] O_HALT_MEM = 12'b1_1_0_1_0_1_0_0_1_0_10;
  localparam logic [11:0] O_RST      = 12'b1_0_1_0_1_0_1_0_1_0_00;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [4:0] idRsAddr, idRtAddr;
  logic idUsesRs, idUsesRt;
  ForwardPort exPort, memPort;
  logic mdStart, redirect, haltId, memReq, memAck;
  logic pcHold, ifIdHold, ifIdClear, idExHold, idExClear;
  logic exMemHold, exMemClear, memWbHold, memWbClear, mdBusy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // reference model: halted flag and remaining mult/div wait cycles
  bit m_halted;
  int m_md_left;

  hazard_sequencer #(.MD_LATENCY(LAT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .idRsAddr(idRsAddr), .idRtAddr(idRtAddr),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exPort(exPort), .memPort(memPort),
    .mdStart(mdStart), .redirect(redirect), .haltId(haltId),
    .memReq(memReq), .memAck(memAck),
    .pcHold(pcHold), .ifIdHold(ifIdHold), .ifIdClear(ifIdClear),
    .idExHold(idExHold), .idExClear(idExClear),
    .exMemHold(exMemHold), .exMemClear(exMemClear),
    .memWbHold(memWbHold), .memWbClear(memWbClear),
    .mdBusy(mdBusy), .state(state)
  );

  always #5 clock = ~clock;

  function automatic ForwardPort fp(input logic w, input logic [4:0] a, input logic e);
    ForwardPort p;
    p.write = w;
    p.addr  = a;
    p.value = $urandom;
    p.eval  = e;
    return p;
  endfunction

  function automatic logic [11:0] outs();
    return {pcHold, ifIdHold, ifIdClear, idExHold, idExClear, exMemHold, exMemClear,
            memWbHold, memWbClear, mdBusy, state};
  endfunction

  function automatic bit hits(input ForwardPort p);
    return p.write && !p.eval && p.addr != 5'd0 &&
           ((idUsesRs && p.addr == idRsAddr) || (idUsesRt && p.addr == idRtAddr));
  endfunction

  function automatic logic [11:0] model_out();
    bit memst, lu, busy;
    logic [1:0] st;
    if (!reset) return O_RST;
    memst = memReq && !memAck;
    lu    = hits(exPort) || hits(memPort);
    busy  = (m_md_left > 0);
    st    = m_halted ? 2'd2 : (busy ? 2'd1 : 2'd0);
    if (memst)         return {9'b1_1_0_1_0_1_0_0_1, busy, st};
    if (busy)          return {9'b1_1_0_1_0_0_1_0_0, busy, st};
    if (m_halted)      return {9'b1_0_1_0_0_0_0_0_0, busy, st};
    if (lu)            return {9'b1_1_0_0_1_0_0_0_0, busy, st};
    if (redirect)      return {9'b0_0_1_0_0_0_0_0_0, busy, st};
    return {9'b0, busy, st};
  endfunction

  task automatic model_step();
    bit memst, lu;
    if (!reset) begin
      m_halted  = 0;
      m_md_left = 0;
      return;
    end
    memst = memReq && !memAck;
    lu    = hits(exPort) || hits(memPort);
    if (m_md_left > 0) m_md_left--;
    else if (!m_halted) begin
      if (mdStart && !memst && LAT > 1) m_md_left = LAT - 1;
      else if (haltId && !memst && !lu) m_halted = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic quiet();
    idRsAddr = 5'd0; idRtAddr = 5'd0; idUsesRs = 1'b0; idUsesRt = 1'b0;
    exPort = fp(1'b0, 5'd0, 1'b0); memPort = fp(1'b0, 5'd0, 1'b0);
    mdStart = 1'b0; redirect = 1'b0; haltId = 1'b0; memReq = 1'b0; memAck = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b0;
    m_halted = 0; m_md_left = 0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (outs() !== O_RST) begin errors++; $display("FAIL reset_hold got=%b exp=%b", outs(), O_RST); end
    else $display("ok reset_hold %b", outs());
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok reset_release %b", outs());
    tick();
  endtask

  task automatic test_load_use();
    quiet();
    exPort = fp(1'b1, 5'd8, 1'b0); idRsAddr = 5'd8; idUsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== O_LU) begin errors++; $display("FAIL lu_ex got=%b exp=%b", outs(), O_LU); end
    else $display("ok lu_ex %b", outs());
    tick();
    exPort = fp(1'b0, 5'd0, 1'b0); memPort = fp(1'b1, 5'd8, 1'b0);
    #1;
    checks++;
    if (outs() !== O_LU) begin errors++; $display("FAIL lu_mem got=%b exp=%b", outs(), O_LU); end
    else $display("ok lu_mem %b", outs());
    tick();
    memPort = fp(1'b1, 5'd8, 1'b1);
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL lu_evald got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok lu_evald %b", outs());
    tick();
  endtask

  task automatic test_zero_nonmatch();
    quiet();
    exPort = fp(1'b1, 5'd0, 1'b0); idRsAddr = 5'd0; idUsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL reg_zero got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok reg_zero %b", outs());
    tick();
    exPort = fp(1'b1, 5'd8, 1'b1); idRsAddr = 5'd8;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL eval_set got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok eval_set %b", outs());
    tick();
    exPort = fp(1'b1, 5'd5, 1'b0); idUsesRs = 1'b0; idRtAddr = 5'd5; idUsesRt = 1'b1;
    #1;
    checks++;
    if (outs() !== O_LU) begin errors++; $display("FAIL rt_match got=%b exp=%b", outs(), O_LU); end
    else $display("ok rt_match %b", outs());
    tick();
    idUsesRt = 1'b0;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL rt_unused got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok rt_unused %b", outs());
    tick();
  endtask

  task automatic test_multdiv();
    logic [11:0] exp_seq [5] = '{O_IDLE, O_MD, O_MD, O_MD, O_IDLE};
    quiet();
    mdStart = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs() !== exp_seq[i]) begin
        errors++; $display("FAIL multdiv cyc%0d got=%b exp=%b", i, outs(), exp_seq[i]);
      end else $display("ok multdiv cyc%0d %b", i, outs());
      tick();
      mdStart = 1'b0;
    end
  endtask

  task automatic test_mem_wait();
    logic [11:0] exp_seq [5] = '{O_MEM, O_MEM, O_MEM, O_LU, O_LU};
    quiet();
    exPort = fp(1'b1, 5'd9, 1'b0); idRsAddr = 5'd9; idUsesRs = 1'b1;
    memReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      memAck = (i == 3);
      memReq = (i <= 3);
      #1;
      checks++;
      if (outs() !== exp_seq[i]) begin
        errors++; $display("FAIL mem_wait cyc%0d got=%b exp=%b", i, outs(), exp_seq[i]);
      end else $display("ok mem_wait cyc%0d %b", i, outs());
      tick();
    end
    quiet();
  endtask

  task automatic test_redirect();
    quiet();
    exPort = fp(1'b1, 5'd3, 1'b0); idRtAddr = 5'd3; idUsesRt = 1'b1; redirect = 1'b1;
    #1;
    checks++;
    if (outs() !== O_LU) begin errors++; $display("FAIL redirect_lu got=%b exp=%b", outs(), O_LU); end
    else $display("ok redirect_lu %b", outs());
    tick();
    idUsesRt = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RED) begin errors++; $display("FAIL redirect_only got=%b exp=%b", outs(), O_RED); end
    else $display("ok redirect_only %b", outs());
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL redirect_done got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok redirect_done %b", outs());
    tick();
  endtask

  task automatic test_random();
    int halted_for = 0;
    logic [11:0] exp_v;
    quiet();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      reset    = !(m_halted && halted_for > 4);
      halted_for = m_halted ? halted_for + 1 : 0;
      idRsAddr = 5'($urandom_range(0, 3));
      idRtAddr = 5'($urandom_range(0, 3));
      idUsesRs = 1'($urandom_range(0, 1));
      idUsesRt = 1'($urandom_range(0, 1));
      exPort   = fp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      memPort  = fp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      mdStart  = ($urandom_range(0, 7) == 0);
      haltId   = !mdStart && ($urandom_range(0, 63) == 0);
      redirect = 1'($urandom_range(0, 1));
      memReq   = ($urandom_range(0, 2) == 0);
      memAck   = 1'($urandom_range(0, 1));
      #1;
      exp_v = model_out();
      checks++;
      if (outs() !== exp_v) begin
        errors++; $display("FAIL random cyc%0d got=%b exp=%b", i, outs(), exp_v);
      end else $display("ok random cyc%0d %b", i, outs());
      tick();
    end
    reset = 1'b1;
    quiet();
    tick();
  endtask

  task automatic test_halt();
    quiet();
    haltId = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL halt_issue got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok halt_issue %b", outs());
    tick();
    haltId = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (outs() !== O_HALT) begin
        errors++; $display("FAIL halted cyc%0d got=%b exp=%b", i, outs(), O_HALT);
      end else $display("ok halted cyc%0d %b", i, outs());
      tick();
    end
    memReq = 1'b1;
    #1;
    checks++;
    if (outs() !== O_HALT_MEM) begin errors++; $display("FAIL halt_mem got=%b exp=%b", outs(), O_HALT_MEM); end
    else $display("ok halt_mem %b", outs());
    tick();
    memReq = 1'b0;
  endtask

  task automatic test_reset_mid_md();
    quiet();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RST) begin errors++; $display("FAIL reset_from_halt got=%b exp=%b", outs(), O_RST); end
    else $display("ok reset_from_halt %b", outs());
    tick();
    reset = 1'b1;
    mdStart = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL md_arm got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok md_arm %b", outs());
    tick();
    mdStart = 1'b0;
    tick();
    #1;
    checks++;
    if (outs() !== O_MD) begin errors++; $display("FAIL md_cnt2 got=%b exp=%b", outs(), O_MD); end
    else $display("ok md_cnt2 %b", outs());
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RST) begin errors++; $display("FAIL reset_mid_md got=%b exp=%b", outs(), O_RST); end
    else $display("ok reset_mid_md %b", outs());
    m_halted = 0; m_md_left = 0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin errors++; $display("FAIL after_reset got=%b exp=%b", outs(), O_IDLE); end
    else $display("ok after_reset %b", outs());
    tick();
  endtask

  initial begin
    quiet();
    @(negedge clock);
    test_reset();
    test_load_use();
    test_zero_nonmatch();
    test_multdiv();
    test_mem_wait();
    test_redirect();
    test_random();
    test_halt();
    test_reset_mid_md();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
